// File: rtl/n_bit_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
package n_bit_pkg;

    localparam int N_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor, diff = a - b - bin, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module n_bit_serial_subtractor
    import n_bit_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = $clog2(N);

    sub_state_t     state;
    sub_state_t     state_nxt;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   diff_sh;
    logic [CNT_W-1:0] cnt;
    logic           borrow;
    logic           d_bit;
    logic           bo_bit;
    logic           last_bit;

    assign last_bit = (cnt == CNT_W'(N - 1));

    full_subtractor u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result shifts in from the MSB, so after N steps bit 0 sits at diff_sh[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            cnt     <= '0;
            borrow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {d_bit, diff_sh[N-1:1]};
                    borrow  <= bo_bit;
                    cnt     <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_sh;
    assign bout = borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[N-1];
            b_msb <= b[N-1];
        end
    end

    assign ovf = out_valid && (a_msb != b_msb) && (diff_sh[N-1] != a_msb);
`endif

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Scoreboard bench for n_bit_serial_subtractor: driver pushes model results, monitor pops on each result handshake.
module tb_n_bit_serial_subtractor;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         out_valid;
    logic         out_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    n_bit_serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the whole words.
    function automatic exp_t model(longint av, longint bv, longint bi);
        exp_t   e;
        longint m = longint'(1) << N;
        longint d = av - bv - bi;
        longint sa = (av >= m / 2) ? av - m : av;
        longint sb = (bv >= m / 2) ? bv - m : bv;
        longint sd = sa - sb - bi;
        e.diff = N'((d + 2 * m) % m);
        e.bout = (av < bv + bi);
        e.ovf  = (sd < -(m / 2)) || (sd > m / 2 - 1);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        q.push_back(model(longint'(av), longint'(bv), longint'(bi)));
        @(negedge clk);
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    // Monitor: compare on every cycle where a result handshake will occur.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("diff", diff, e.diff);
                    check("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
                    check("ovf", ovf, e.ovf);
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   cyc;
        exp_t e_bp;

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // First operation also measures acceptance-to-valid latency.
        issue(16'd120, 16'd12, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, N);
        drain();

        issue(16'd12, 16'd120, 1'b1);
        issue(16'd0, 16'd0, 1'b1);
        issue(16'h8000, 16'd1, 1'b0);
        issue(16'd5, 16'd3, 1'b0);
        issue(16'hFFFF, 16'h7FFF, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        drain();

        // Backpressure: result must hold while out_ready is low and in_valid pulses.
        out_ready = 1'b0;
        issue(16'h1234, 16'h0F0F, 1'b1);
        e_bp = model(64'h1234, 64'h0F0F, 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_valid_timeout", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = N'($urandom);
            b        = N'($urandom);
            @(negedge clk);
            check("bp_diff", diff, e_bp.diff);
            check("bp_bout", bout, e_bp.bout);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        issue(16'd40000, 16'd12345, 1'b0);
        drain();

        // Reset after bit 7 of RUN aborts the operation.
        issue(16'hABCD, 16'h1357, 1'b1);
        repeat (8) @(negedge clk);
        check("mid_out_valid", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        issue(16'd1000, 16'd1, 1'b0);
        drain();

        // Randomized operands with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(N'($urandom), N'($urandom), 1'($urandom));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/n_bit_serial_subtractor.md
# n_bit_serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock through a single 1-bit full-subtractor cell. It is the inverse-operation counterpart of the team's parallel `N_bit_adder`, and trades latency for area. Operands enter and results leave through valid/ready handshakes, so the block drops into the same datapaths as the adder with registered, flow-controlled boundaries.

## Interface
Parameters:
- `N`, default 16: operand width; legal range N >= 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, synchronous, active-high.
- `a`  input  N  minuend.
- `b`  input  N  subtrahend.
- `bin`  input  1  borrow in.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands.
- `diff`  output  N  result `(a - b - bin) mod 2^N`.
- `bout`  output  1  borrow out; 1 iff unsigned `a < b + bin`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready = 1`.
  - On an edge with `in_valid && in_ready`: latch `a`, `b`, `bin` into shift registers; clear the bit counter; seed the borrow flop with `bin`; go to RUN.
- RUN:
  - `in_ready = 0`.
  - Each edge: the full-subtractor cell takes LSB(a_sh), LSB(b_sh) and the borrow flop.
  - The difference bit shifts into the MSB of `diff_sh`; the new borrow updates the borrow flop; the operand shifters shift right; the counter increments.
  - On the edge where counter == N-1 (the Nth bit): go to DONE.
- DONE:
  - `out_valid = 1`; `diff`, `bout` (and `ovf`) are stable and held.
  - On an edge with `out_valid && out_ready`: go to IDLE.
  - No new operand is accepted while in DONE.
- Arithmetic:
  - `diff` wraps modulo 2^N.
  - `bout` is the final borrow flop value.
  - `ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1])`, using latched operand MSBs.
- `in_valid` and operand values outside IDLE are ignored and need not be held.
- Counter width: `$clog2(N)`.

## Timing
- Reset values: state IDLE, `in_ready` = 1 in the cycle after the reset edge, `out_valid` = 0, `diff` = 0, `bout` = 0, `ovf` = 0.
- Latency: acceptance at edge k; `out_valid` rises after edge k+N; earliest result handshake at edge k+N+1.
- Throughput: one operation per N+2 cycles with `out_ready` held high.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from inputs.
- Backpressure: with `out_ready` low, DONE persists indefinitely and outputs do not change.
- `in_ready` is 1 in the cycle after the result handshake edge.
- Reset mid-RUN or mid-DONE:
  - The operation is aborted; all outputs take reset values at the next edge.
  - No partial result is ever presented.
- `rst` high overrides any handshake on the same edge.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists and is computed as above.
  - Registered operand MSB flops are retained.
- Not defined:
  - `ovf` port is absent; MSB flops are omitted.
  - All other behaviour is identical.

## Structure
- Package `n_bit_pkg`:
  - Default width constant `N_DEFAULT = 16`.
  - FSM state enum `sub_state_t` (IDLE, RUN, DONE).
- Sub-module `full_subtractor`:
  - Combinational 1-bit cell.
  - Ports `x`, `y`, `bi`, `d`, `bo`.
  - `d = x ^ y ^ bi`; `bo = (~x & y) | (~(x ^ y) & bi)`.

## Test plan
- a=120, b=12, bin=1 -> `diff` = 107, `bout` = 0, `out_valid` after exactly 16 RUN cycles.
- a=12, b=120, bin=1 -> `diff` = 65427, `bout` = 1.
- a=0, b=0, bin=1 -> `diff` = 65535, `bout` = 1 (full borrow ripple).
- a=16'h8000, b=1, bin=0 -> `diff` = 16'h7FFF, `bout` = 0, `ovf` = 1 (macro defined); a=5, b=3 -> `ovf` = 0.
- `out_ready` held low 5 cycles after `out_valid`:
  - `diff`/`bout` stable; `in_ready` = 0; `in_valid` pulses ignored.
  - Release -> IDLE next cycle; back-to-back second operation correct.
- Assert `rst` after bit 7 of RUN:
  - Next cycle all outputs are 0 and `in_ready` = 1.
  - A fresh operation a=1000, b=1, bin=0 returns 999 with no residue from the aborted one.
